// File: rtl/hub75_regs_pkg.sv
// hub75_regs_pkg: register indices, IRQ bit positions and reset constants shared by the Hub75 APB block.
package hub75_regs_pkg;
    localparam logic [5:0] IDX_STATUS   = 6'd0;
    localparam logic [5:0] IDX_ID       = 6'd1;
    localparam logic [5:0] IDX_SWAP     = 6'd2;
    localparam logic [5:0] IDX_IRQ_STAT = 6'd3;
    localparam logic [5:0] IDX_IRQ_EN   = 6'd4;
    localparam logic [5:0] IDX_PPROW    = 6'd5;
    localparam logic [5:0] CTRL_BASE    = 6'd8;
    localparam int IRQ_SWAP  = 0;
    localparam int IRQ_FRAME = 1;
    localparam logic [31:0] DEFAULT_CTRL0 = 32'h1;
    localparam logic [9:0]  DEFAULT_PPROW = 10'd64;
    localparam logic [31:0] ID_VALUE      = 32'hDEADBEEF;
    localparam logic [31:0] PPROW_MAX     = 32'd512;
    function automatic logic pprow_legal(input logic [31:0] v);
        return v != 32'd0 && v <= PPROW_MAX;
    endfunction
endpackage

// File: rtl/hub75_apb_regs_if.sv
// hub75_apb_regs_if: APB bus between the MSS fabric master and the Hub75 register slave.
interface hub75_apb_regs_if #(parameter int ADDR_W = 18);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/hub75_bank_swap.sv
// hub75_bank_swap: double-buffer bank selection, swapping on end-of-frame when a swap is pending.
module hub75_bank_swap (
    input  logic clk,
    input  logic rst_n,
    input  logic swap_req,
    input  logic frame_done,
    output logic swap_pending,
    output logic disp_bank,
    output logic fb_bank,
    output logic swap_done
);
    // A request landing on the same frame_done defers the swap to the next frame.
    assign swap_done = frame_done && swap_pending && !swap_req;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pending <= 1'b0;
            disp_bank    <= 1'b0;
            fb_bank      <= 1'b1;
        end else begin
            swap_pending <= swap_req || (swap_pending && !swap_done);
            if (swap_done) begin
                disp_bank <= !disp_bank;
                fb_bank   <= disp_bank;
            end
        end
    end
endmodule

// File: rtl/hub75_apb_regs.sv
// hub75_apb_regs: APB control/status registers, back-pressured frame-buffer write port and
// end-of-frame bank swapping with a maskable interrupt for the Hub75 cape.
module hub75_apb_regs
    import hub75_regs_pkg::*;
#(
    parameter int NUM_CTRL = 4,
    parameter int ADDR_W   = 18,
    parameter int FB_AW    = 15,
    parameter int DATA_W   = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    hub75_apb_regs_if.slave       apb,
    input  logic [31:0]           status_in,
    input  logic                  frame_done,
    input  logic                  fb_ready,
    output logic [32*NUM_CTRL-1:0] ctrl,
    output logic [9:0]            pixels_per_row,
    output logic                  fb_wr,
    output logic [FB_AW-1:0]      fb_waddr,
    output logic [DATA_W-1:0]     fb_wdata,
    output logic                  fb_bank,
    output logic                  disp_bank,
    output logic                  irq
);
    logic [NUM_CTRL-1:0][31:0] ctrl_q;
    logic [1:0]  irq_en, irq_stat, irq_set;
    logic [31:0] rd_data;
    logic [5:0]  idx;
    logic reg_sp, setup, wr, rd_err, rd_err_q, wr_err, ctrl_hit;
    logic swap_req, swap_pending, swap_done, unused_paddr;

    assign reg_sp       = apb.paddr[ADDR_W-1];
    assign idx          = apb.paddr[7:2];
    assign unused_paddr = ^apb.paddr;
    assign setup        = apb.psel && !apb.penable;
    assign apb.pready   = !(fb_wr && !fb_ready);
    assign wr           = apb.psel && apb.penable && apb.pwrite && apb.pready;
    assign swap_req     = wr && reg_sp && idx == IDX_SWAP && apb.pwdata[0];
    assign apb.pslverr  = rd_err_q || (apb.psel && apb.penable && apb.pwrite && wr_err);
    assign ctrl         = ctrl_q;

    hub75_bank_swap u_swap (
        .clk          (pclk),
        .rst_n        (presetn),
        .swap_req     (swap_req),
        .frame_done   (frame_done),
        .swap_pending (swap_pending),
        .disp_bank    (disp_bank),
        .fb_bank      (fb_bank),
        .swap_done    (swap_done)
    );

    always_comb begin
        rd_data  = '0;
        ctrl_hit = 1'b0;
        irq_set  = '0;
        irq_set[IRQ_SWAP]  = swap_done;
        irq_set[IRQ_FRAME] = frame_done;
        for (int i = 0; i < NUM_CTRL; i++)
            if (idx == 6'(CTRL_BASE + 6'(i))) begin
                ctrl_hit = 1'b1;
                rd_data  = ctrl_q[i];
            end
        case (idx)
            IDX_STATUS:   rd_data = status_in;
            IDX_ID:       rd_data = ID_VALUE;
            IDX_SWAP:     rd_data = {29'd0, swap_pending, disp_bank, fb_bank};
            IDX_IRQ_STAT: rd_data = {30'd0, irq_stat};
            IDX_IRQ_EN:   rd_data = {30'd0, irq_en};
            IDX_PPROW:    rd_data = {22'd0, pixels_per_row};
            default:      ;
        endcase
        rd_err = reg_sp && idx > IDX_PPROW && !ctrl_hit;
        rd_data = reg_sp && !rd_err ? rd_data : '0;
        wr_err = reg_sp && (idx == IDX_STATUS || idx == IDX_ID ||
                 (idx == IDX_PPROW && !pprow_legal(apb.pwdata)));
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            apb.prdata     <= '0;
            rd_err_q       <= 1'b0;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= i == 0 ? DEFAULT_CTRL0 : '0;
            pixels_per_row <= DEFAULT_PPROW;
            irq_en         <= '0;
            irq_stat       <= '0;
            irq            <= 1'b0;
            fb_wr          <= 1'b0;
            fb_waddr       <= '0;
            fb_wdata       <= '0;
        end else begin
            if (setup) begin
                apb.prdata <= apb.pwrite ? '0 : rd_data;
                rd_err_q   <= !apb.pwrite && rd_err;
            end
            irq <= |(irq_stat & irq_en);
            // New events take precedence over a simultaneous write-1-to-clear.
            irq_stat <= (wr && reg_sp && idx == IDX_IRQ_STAT ? irq_stat & ~apb.pwdata[1:0] : irq_stat) | irq_set;
            if (wr && reg_sp) begin
                if (idx == IDX_IRQ_EN) irq_en <= apb.pwdata[1:0];
                if (idx == IDX_PPROW && pprow_legal(apb.pwdata)) pixels_per_row <= apb.pwdata[9:0];
                for (int i = 0; i < NUM_CTRL; i++)
                    if (idx == 6'(CTRL_BASE + 6'(i))) ctrl_q[i] <= apb.pwdata;
            end
            if (wr && !reg_sp) begin
                fb_wr    <= 1'b1;
                fb_waddr <= apb.paddr[FB_AW+1:2];
                fb_wdata <= apb.pwdata[DATA_W-1:0];
            end else if (fb_ready) begin
                fb_wr <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hub75_apb_regs.sv
// tb_hub75_apb_regs: directed and randomized checks of hub75_apb_regs against a behavioural register model.
module tb_hub75_apb_regs;
    localparam int NC = 4, AW = 18, FAW = 15, DW = 16;
    localparam logic [AW-1:0] REGS = 18'h20000;

    logic pclk = 1'b0, presetn = 1'b0, frame_done = 1'b0, fb_ready = 1'b1;
    logic [31:0] status_in = '0;
    logic [32*NC-1:0] ctrl;
    logic [9:0] ppr;
    logic fb_wr, fb_bank, disp_bank, irq;
    logic [FAW-1:0] fb_waddr;
    logic [DW-1:0] fb_wdata;
    int tests = 0, fails = 0;

    logic [31:0] m_ctrl [NC];
    logic [9:0]  m_ppr;
    logic [1:0]  m_en, m_stat;
    logic        m_pend, m_disp;

    always #5 pclk = ~pclk;

    hub75_apb_regs_if #(.ADDR_W(AW)) apb();

    hub75_apb_regs #(.NUM_CTRL(NC), .ADDR_W(AW), .FB_AW(FAW), .DATA_W(DW)) dut (
        .pclk(pclk), .presetn(presetn), .apb(apb), .status_in(status_in),
        .frame_done(frame_done), .fb_ready(fb_ready), .ctrl(ctrl),
        .pixels_per_row(ppr), .fb_wr(fb_wr), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
        .fb_bank(fb_bank), .disp_bank(disp_bank), .irq(irq)
    );

    function automatic logic [AW-1:0] ra(input int i);
        return REGS | AW'(i * 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err);
        int n;
        @(posedge pclk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = w; apb.paddr = a; apb.pwdata = d;
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        #1;
        n = 0;
        while (!apb.pready && n < 50) begin
            @(posedge pclk); #2;
            n++;
        end
        if (n >= 50) begin
            fails++;
            $error("FAIL pready_timeout: observed stalled %0d cycles required under 50", n);
        end
        rd = apb.prdata;
        err = apb.pslverr;
        @(posedge pclk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic pulse_frame();
        @(posedge pclk); #1 frame_done = 1'b1;
        @(posedge pclk); #1 frame_done = 1'b0;
    endtask

    function automatic void exp_read(input int k, output logic [31:0] d, output logic e);
        d = '0;
        e = 1'b0;
        if (k == 0) d = status_in;
        else if (k == 1) d = 32'hDEADBEEF;
        else if (k == 2) d = {29'd0, m_pend, m_disp, ~m_disp};
        else if (k == 3) d = {30'd0, m_stat};
        else if (k == 4) d = {30'd0, m_en};
        else if (k == 5) d = {22'd0, m_ppr};
        else if (k >= 8 && k < 8 + NC) d = m_ctrl[k-8];
        else e = 1'b1;
    endfunction

    initial begin
        logic [31:0] d, v, ed;
        logic e, ee;
        logic [AW-1:0] a;
        int k;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        check("rst_prdata", apb.prdata, 32'd0);
        check("rst_pslverr", 32'(apb.pslverr), 32'd0);
        check("rst_pready", 32'(apb.pready), 32'd1);
        check("rst_ctrl0", ctrl[31:0], 32'd1);
        check("rst_ctrl3", ctrl[127:96], 32'd0);
        check("rst_pprow", 32'(ppr), 32'd64);
        check("rst_fb", {fb_wr, 15'(fb_waddr), 16'(fb_wdata)}, 32'd0);
        check("rst_banks", {30'd0, fb_bank, disp_bank}, 32'd2);
        check("rst_irq", 32'(irq), 32'd0);
        presetn = 1'b1;

        xfer(1'b0, ra(1), 0, d, e); check("rd_id", d, 32'hDEADBEEF); check("rd_id_err", 32'(e), 0);
        xfer(1'b0, ra(8), 0, d, e); check("rd_ctrl0", d, 32'd1); check("rd_ctrl0_err", 32'(e), 0);
        xfer(1'b0, ra(5), 0, d, e); check("rd_pprow", d, 32'd64);

        xfer(1'b1, ra(10), 32'hA5A5_0F0F, d, e);
        check("wr_ctrl2", ctrl[95:64], 32'hA5A5_0F0F); check("wr_ctrl2_err", 32'(e), 0);
        xfer(1'b1, ra(5), 300, d, e); check("wr_pprow", 32'(ppr), 300); check("wr_pprow_err", 32'(e), 0);
        xfer(1'b1, ra(5), 0, d, e); check("wr_pprow0_err", 32'(e), 1); check("wr_pprow0_keep", 32'(ppr), 300);
        xfer(1'b1, ra(5), 513, d, e); check("wr_pprow513_err", 32'(e), 1); check("wr_pprow513_keep", 32'(ppr), 300);
        xfer(1'b1, ra(5), 512, d, e); check("wr_pprow512", 32'(ppr), 512); check("wr_pprow512_err", 32'(e), 0);

        fb_ready = 1'b0;
        xfer(1'b1, 18'h00124, 32'h0001_F81F, d, e);
        check("fb_wr", 32'(fb_wr), 1); check("fb_waddr", 32'(fb_waddr), 32'h49);
        check("fb_wdata", 32'(fb_wdata), 32'hF81F); check("fb_err", 32'(e), 0);
        repeat (3) @(posedge pclk);
        #1;
        check("fb_hold", {fb_wr, 15'(fb_waddr), 16'(fb_wdata)}, {1'b1, 15'h49, 16'hF81F});
        @(posedge pclk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 18'h00200; apb.pwdata = 32'h1234_5678;
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fb_stall_pready", 32'(apb.pready), 0);
            check("fb_stall_hold", {fb_wr, 15'(fb_waddr), 16'(fb_wdata)}, {1'b1, 15'h49, 16'hF81F});
            @(posedge pclk); #1;
        end
        fb_ready = 1'b1;
        #1 check("fb_release_pready", 32'(apb.pready), 1);
        @(posedge pclk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0;
        check("fb_second", {fb_wr, 15'(fb_waddr), 16'(fb_wdata)}, {1'b1, 15'h80, 16'h5678});
        @(posedge pclk); #1;
        check("fb_drop", 32'(fb_wr), 0);

        xfer(1'b1, ra(4), 1, d, e);
        xfer(1'b1, ra(2), 1, d, e); check("swap_wr_err", 32'(e), 0);
        xfer(1'b0, ra(2), 0, d, e); check("swap_pending_rd", d, 32'd5);
        pulse_frame();
        check("swap_banks", {30'd0, fb_bank, disp_bank}, 32'd1);
        check("swap_irq_early", 32'(irq), 0);
        @(posedge pclk); #1;
        check("swap_irq", 32'(irq), 1);
        xfer(1'b0, ra(2), 0, d, e); check("swap_done_rd", d, 32'd2);
        xfer(1'b1, ra(3), 1, d, e);
        @(posedge pclk); #1;
        check("w1c_irq", 32'(irq), 0);
        xfer(1'b0, ra(3), 0, d, e); check("irq_stat_rd", d, 32'd2);

        @(posedge pclk); #1;
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = ra(2); apb.pwdata = 1;
        @(posedge pclk); #1;
        apb.penable = 1'b1; frame_done = 1'b1;
        @(posedge pclk); #1;
        apb.psel = 1'b0; apb.penable = 1'b0; frame_done = 1'b0;
        check("coinc_no_toggle", 32'(disp_bank), 1);
        xfer(1'b0, ra(2), 0, d, e); check("coinc_pending", d, 32'd6);
        pulse_frame();
        check("coinc_next_toggle", {30'd0, fb_bank, disp_bank}, 32'd2);

        xfer(1'b0, ra(7), 0, d, e); check("unmapped_rd", d, 0); check("unmapped_err", 32'(e), 1);
        xfer(1'b1, ra(0), 32'h1111, d, e); check("status_wr_err", 32'(e), 1);
        xfer(1'b1, ra(1), 32'h1111, d, e); check("id_wr_err", 32'(e), 1);
        xfer(1'b0, ra(1), 0, d, e); check("id_keep", d, 32'hDEADBEEF);
        xfer(1'b0, 18'h00040, 0, d, e); check("fb_rd", d, 0); check("fb_rd_err", 32'(e), 0);

        fb_ready = 1'b0;
        xfer(1'b1, ra(2), 1, d, e);
        xfer(1'b1, 18'h00abc, 32'hFFFF, d, e);
        check("pre_rst_fb_wr", 32'(fb_wr), 1);
        #2 presetn = 1'b0;
        #1 check("mid_rst_fb", {fb_wr, 15'(fb_waddr), 16'(fb_wdata)}, 32'd0);
        @(posedge pclk); #1 presetn = 1'b1; fb_ready = 1'b1;
        xfer(1'b0, ra(2), 0, d, e); check("rst_swap_cleared", d, 32'd1);

        for (int i = 0; i < NC; i++) m_ctrl[i] = i == 0 ? 32'd1 : 32'd0;
        m_ppr = 10'd64; m_en = '0; m_stat = '0; m_pend = 1'b0; m_disp = 1'b0;
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 7))
                0: begin
                    k = $urandom_range(0, NC-1); v = $urandom;
                    xfer(1'b1, ra(8+k), v, d, e); m_ctrl[k] = v;
                    check("rnd_ctrl", ctrl[k*32 +: 32], v); check("rnd_ctrl_err", 32'(e), 0);
                end
                1: begin
                    v = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 600);
                    xfer(1'b1, ra(5), v, d, e);
                    if (v >= 1 && v <= 512) m_ppr = v[9:0];
                    check("rnd_pprow_err", 32'(e), 32'(!(v >= 1 && v <= 512)));
                    check("rnd_pprow", 32'(ppr), 32'(m_ppr));
                end
                2: begin
                    status_in = $urandom;
                    if ($urandom_range(0, 4) == 0) begin
                        a = AW'($urandom) & ~REGS;
                        xfer(1'b0, a, 0, d, e);
                        check("rnd_fb_rd", d, 0); check("rnd_fb_rd_err", 32'(e), 0);
                    end else begin
                        k = $urandom_range(0, 15);
                        exp_read(k, ed, ee);
                        xfer(1'b0, ra(k), 0, d, e);
                        check("rnd_rd", d, ed); check("rnd_rd_err", 32'(e), 32'(ee));
                    end
                end
                3: begin
                    pulse_frame();
                    m_stat[1] = 1'b1;
                    if (m_pend) begin m_disp = ~m_disp; m_pend = 1'b0; m_stat[0] = 1'b1; end
                    check("rnd_banks", {30'd0, fb_bank, disp_bank}, {30'd0, ~m_disp, m_disp});
                end
                4: begin
                    v = $urandom; xfer(1'b1, ra(2), v, d, e); m_pend = m_pend | v[0];
                    check("rnd_swap_err", 32'(e), 0);
                end
                5: begin
                    v = $urandom; xfer(1'b1, ra(3), v, d, e); m_stat = m_stat & ~v[1:0];
                    check("rnd_w1c_err", 32'(e), 0);
                end
                6: begin
                    v = $urandom; xfer(1'b1, ra(4), v, d, e); m_en = v[1:0];
                    check("rnd_en_err", 32'(e), 0);
                end
                default: begin
                    a = AW'($urandom) & ~REGS; v = $urandom;
                    xfer(1'b1, a, v, d, e);
                    check("rnd_fb", {fb_wr, 15'(fb_waddr), 16'(fb_wdata)}, {1'b1, 15'(a[FAW+1:2]), v[15:0]});
                end
            endcase
            @(posedge pclk); #1;
            check("rnd_irq", 32'(irq), 32'(|(m_stat & m_en)));
            check("rnd_fb_idle", 32'(fb_wr), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
